// File: rtl/lab7soc_pio_pkg.sv
// Shared constants for the lab7soc interrupt-capable input PIO.
package lab7soc_pio_pkg;

  // Avalon word addresses of the register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which transitions of the synchronised input set an EDGECAP bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // What drives the interrupt: masked input level or masked captured edges
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/lab7soc_pio_sync.sv
// Multi-flop synchroniser for the external input bus, plus a one-cycle
// delayed copy used to detect per-bit transitions of the synchronised value.
module lab7soc_pio_sync
  import lab7soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // Shift the raw input through the synchroniser chain; prev trails data by one cycle.
  // prev resets to the same value as the chain so no edge is seen straight out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= RESET_VALUE;
      r_prev <= RESET_VALUE;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_data = r_sync[SYNC_STAGES-1];
  assign w_rise = o_data & ~r_prev;
  assign w_fall = ~o_data & r_prev;

  // Select the transition type that counts as an edge for this instance.
  always_comb begin
    o_edge = w_rise;
    if (EDGE_TYPE == EDGE_FALL)     o_edge = w_fall;
    else if (EDGE_TYPE == EDGE_ANY) o_edge = w_rise | w_fall;
  end

endmodule

// File: rtl/lab7soc_pio_in_irq.sv
// Avalon-MM input PIO with synchronised DATA, per-bit edge capture
// (write-1-to-clear), interrupt mask and a level- or edge-driven IRQ.
module lab7soc_pio_in_irq
  import lab7soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               IRQ_MODE    = IRQ_LEVEL,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_mask;
  logic             w_wr_cap;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_capture;
  logic [31:0]      r_readdata;

  // Pad a WIDTH-bit register value into the 32-bit bus; a plain slice
  // assignment keeps WIDTH=32 free of a zero-width replication.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r           = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  lab7soc_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (in_port),
    .o_data  (w_data),
    .o_edge  (w_edge)
  );

  assign w_wr_mask = chipselect & write & (address == ADDR_IRQMASK);
  assign w_wr_cap  = chipselect & write & (address == ADDR_EDGECAP);
  assign w_clr     = w_wr_cap ? writedata[WIDTH-1:0] : '0;

  // Upper writedata bits are architecturally dropped when WIDTH < 32.
  assign w_unused_wdata = ^writedata;

  // Interrupt mask register; only the low WIDTH bits are kept.
  always_ff @(posedge clk) begin
    if (reset)          r_mask <= '0;
    else if (w_wr_mask) r_mask <= writedata[WIDTH-1:0];
  end

  // Edge capture: clear-on-write-1, with a same-cycle edge taking priority.
  always_ff @(posedge clk) begin
    if (reset) r_capture <= '0;
    else       r_capture <= (r_capture & ~w_clr) | w_edge;
  end

  // Address decode for reads; the reserved word and idle bus return zero.
  always_comb begin
    w_rd_mux = '0;
    if (chipselect & read) begin
      case (address)
        ADDR_DATA:    w_rd_mux = zext(w_data);
        ADDR_IRQMASK: w_rd_mux = zext(r_mask);
        ADDR_EDGECAP: w_rd_mux = zext(r_capture);
        default:      w_rd_mux = '0;
      endcase
    end
  end

  // Registered read data, loaded every cycle so it is zero outside reads.
  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;
  assign irq = (IRQ_MODE == IRQ_EDGE) ? |(r_capture & r_mask) : |(w_data & r_mask);

endmodule

// File: tb/tb_lab7soc_pio_in_irq.sv
// Bench for lab7soc_pio_in_irq: two differently configured instances share
// one bus; a history-based model predicts readdata and irq every cycle.
module tb_lab7soc_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdat = '0;
  logic [3:0]  in = '0;
  logic [31:0] rdata_e, rdata_l;
  logic        irq_e, irq_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: rising-edge capture, edge-driven irq, 2 sync stages, reset value 0
  lab7soc_pio_in_irq #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1), .RESET_VALUE(4'h0)
  ) u_edge (
    .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .read(rd),
    .write(wr), .writedata(wdat), .readdata(rdata_e), .irq(irq_e), .in_port(in)
  );

  // Instance 1: any-edge capture, level irq, 3 sync stages, reset value 6
  lab7soc_pio_in_irq #(
    .WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(0), .RESET_VALUE(4'h6)
  ) u_lvl (
    .clk(clk), .reset(reset), .address(addr), .chipselect(cs), .read(rd),
    .write(wr), .writedata(wdat), .readdata(rdata_l), .irq(irq_l), .in_port(in)
  );

  // Instance parameters as seen by the model
  function automatic int p_stages(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int p_edge(int i);   return (i == 0) ? 0 : 2; endfunction
  function automatic int p_irq(int i);    return (i == 0) ? 1 : 0; endfunction
  function automatic logic [3:0] p_rv(int i); return (i == 0) ? 4'h0 : 4'h6; endfunction

  // Model state: raw input samples taken since reset, plus architectural registers
  logic [3:0]  hist[$];
  logic [3:0]  m_cap [2];
  logic [3:0]  m_mask[2];
  logic [31:0] m_rd  [2];
  bit          started = 0;

  // Synchronised value seen d cycles back: the sample taken d edges ago, else reset value
  function automatic logic [3:0] seen(int i, int d);
    if (hist.size() >= d) return hist[hist.size() - d];
    return p_rv(i);
  endfunction

  function automatic logic exp_irq(int i);
    if (p_irq(i) == 1) return |(m_cap[i] & m_mask[i]);
    return |(seen(i, p_stages(i)) & m_mask[i]);
  endfunction

  // Reference model advances on each rising edge from the bus values present before it
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        hist.delete();
        for (int i = 0; i < 2; i++) begin
          m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
        end
        started = 1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          logic [3:0] d, p, e, clr;
          d = seen(i, p_stages(i));
          p = seen(i, p_stages(i) + 1);
          case (p_edge(i))
            0:       e = d & ~p;
            1:       e = ~d & p;
            default: e = d ^ p;
          endcase
          m_rd[i] = '0;
          if (cs && rd) begin
            case (addr)
              2'd0:    m_rd[i] = {28'h0, d};
              2'd2:    m_rd[i] = {28'h0, m_mask[i]};
              2'd3:    m_rd[i] = {28'h0, m_cap[i]};
              default: m_rd[i] = '0;
            endcase
          end
          clr = (cs && wr && addr == 2'd3) ? wdat[3:0] : 4'h0;
          m_cap[i] = (m_cap[i] & ~clr) | e;
          if (cs && wr && addr == 2'd2) m_mask[i] = wdat[3:0];
        end
        hist.push_back(in);
        if (hist.size() > 8) void'(hist.pop_front());
      end
    end
  end

  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", name, inst, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model, 1 time unit after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        cmp("readdata", 0, rdata_e, m_rd[0]);
        cmp("irq", 0, {31'h0, irq_e}, {31'h0, exp_irq(0)});
        cmp("readdata", 1, rdata_l, m_rd[1]);
        cmp("irq", 1, {31'h0, irq_l}, {31'h0, exp_irq(1)});
      end
    end
  end

  task automatic bus(input logic [1:0] a, input logic r, input logic w, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; addr = a; rd = r; wr = w; wdat = d;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset, then every address reads zero and irq is low
    idle(3);
    reset = 1'b0;
    idle(4);
    cmp("lit_irq_after_reset", 0, {31'h0, irq_e}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus(2'(a), 1'b1, 1'b0, 32'h0);
      cmp("lit_read_after_reset", 0, rdata_e, 32'h0);
    end

    // DATA reflects the synchronised input
    in = 4'hA;
    idle(4);
    bus(2'd0, 1'b1, 1'b0, 32'h0);
    cmp("lit_data_A", 0, rdata_e, 32'h0000000A);
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_cap_rise_A", 0, rdata_e, 32'h0000000A);
    bus(2'd3, 1'b0, 1'b1, 32'hF);
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_cap_cleared", 0, rdata_e, 32'h0);

    // Falling edges alone capture nothing on the rising-edge instance
    in = 4'h0;
    idle(4);
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_fall_no_cap", 0, rdata_e, 32'h0);

    // One-cycle pulse on bit1 is captured, then cleared by writing 1
    in = 4'h2;
    idle(1);
    in = 4'h0;
    idle(4);
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_cap_pulse", 0, rdata_e, 32'h2);
    bus(2'd3, 1'b0, 1'b1, 32'h2);
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_cap_w1c", 0, rdata_e, 32'h0);

    // Edge-mode irq follows the masked capture
    bus(2'd2, 1'b0, 1'b1, 32'h2);
    in = 4'h2;
    idle(4);
    cmp("lit_irq_edge_set", 0, {31'h0, irq_e}, 32'h1);
    bus(2'd3, 1'b0, 1'b1, 32'h2);
    cmp("lit_irq_edge_clr", 0, {31'h0, irq_e}, 32'h0);
    in = 4'h0;
    idle(4);

    // Clear and new edge in the same cycle: the set wins
    @(negedge clk); in = 4'h2;
    @(negedge clk);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = 2'd3; wdat = 32'h2;
    @(posedge clk); #1;
    cmp("lit_set_wins_irq", 0, {31'h0, irq_e}, 32'h1);
    @(negedge clk); cs = 1'b0; wr = 1'b0;
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_set_wins_cap", 0, rdata_e, 32'h2);

    // Level-mode irq follows masked data
    bus(2'd2, 1'b0, 1'b1, 32'h1);
    in = 4'h1;
    idle(5);
    cmp("lit_irq_level_set", 1, {31'h0, irq_l}, 32'h1);
    bus(2'd2, 1'b0, 1'b1, 32'h0);
    cmp("lit_irq_level_clr", 1, {31'h0, irq_l}, 32'h0);
    bus(2'd2, 1'b0, 1'b1, 32'hFFFFFFFF);
    bus(2'd2, 1'b1, 1'b0, 32'h0);
    cmp("lit_mask_readback", 0, rdata_e, 32'h0000000F);
    cmp("lit_mask_readback", 1, rdata_l, 32'h0000000F);

    // Reset during a pending capture overrides a same-cycle write
    bus(2'd3, 1'b0, 1'b1, 32'hF);
    in = 4'h0;
    idle(4);
    in = 4'h2;
    idle(4);
    cmp("lit_irq_pending", 0, {31'h0, irq_e}, 32'h1);
    @(negedge clk);
    reset = 1'b1; in = 4'h0; cs = 1'b1; wr = 1'b1; addr = 2'd2; wdat = 32'hF;
    @(posedge clk); #1;
    cmp("lit_irq_reset", 0, {31'h0, irq_e}, 32'h0);
    @(negedge clk);
    reset = 1'b0; cs = 1'b0; wr = 1'b0;
    bus(2'd2, 1'b1, 1'b0, 32'h0);
    cmp("lit_mask_reset", 0, rdata_e, 32'h0);
    bus(2'd3, 1'b1, 1'b0, 32'h0);
    cmp("lit_cap_reset", 0, rdata_e, 32'h0);

    // Randomised traffic, checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) in = 4'($urandom);
      cs   = ($urandom_range(0, 3) != 0);
      rd   = 1'($urandom);
      wr   = 1'($urandom);
      addr = 2'($urandom);
      wdat = ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << $urandom_range(0, 3));
    end
    @(negedge clk);
    reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
